// File: rtl/pool_pkg.sv
// Shared definitions for the ForthSuper memory pool: dictionary header layout
// and the dict_add state encoding.
package pool_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_LEN,
    ST_LFA0,
    ST_LFA1,
    ST_PF0,
    ST_PF1,
    ST_DONE,
    ST_ERR
  } da_state_t;

  localparam logic [15:0] LFA_NULL = 16'hffff;

  localparam int unsigned OFS_LFA  = 0;
  localparam int unsigned OFS_LEN  = 2;
  localparam int unsigned OFS_NAME = 3;
  localparam int unsigned PFA_SZ   = 2;

endpackage

// File: rtl/dict_add.sv
// Dictionary header writer: copies a null-terminated TIB name into a new entry
// at HERE (lfa, len, name, xt), then links it into the chain and bumps HERE.
module dict_add
  import pool_pkg::*;
#(
  parameter int ASZ    = 17,
  parameter int DSZ    = 8,
  parameter logic [15:0] DICT = 16'h0010,
  parameter int MAXLEN = 31
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [ASZ-1:0] ai,
  input  logic [15:0]    xt,
  output logic           bsy,
  output logic           done,
  output logic           err,
  output logic [15:0]    lfa,
  output logic [15:0]    here,
  output logic [ASZ-1:0] mem_ai,
  output logic [DSZ-1:0] mem_vi,
  output logic           mem_we,
  input  logic [DSZ-1:0] mem_vo
);

  localparam int IW = $clog2(MAXLEN + 2);

  da_state_t      state_q, state_d;
  logic [IW-1:0]  i_q, i_d;
  logic [ASZ-1:0] ai_q, ai_d;
  logic [15:0]    xt_q, xt_d;
  logic [15:0]    lfa_q, lfa_d;
  logic [15:0]    here_q, here_d;

  logic [15:0]    hofs;
  logic [15:0]    hadr;
  logic [ASZ-1:0] tadr;
  logic           use_tib;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lfa_q   <= LFA_NULL;
      here_q  <= DICT;
    end else begin
      state_q <= state_d;
      lfa_q   <= lfa_d;
      here_q  <= here_d;
    end
  end

  // Command payload and name index need no reset: only read outside IDLE.
  always_ff @(posedge clk) begin
    i_q  <= i_d;
    ai_q <= ai_d;
    xt_q <= xt_d;
  end

  // Two shared adders: one for the TIB side, one for HERE-relative header bytes.
  assign tadr = ai_q + ASZ'(i_q);
  assign hadr = here_q + hofs;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    ai_d    = ai_q;
    xt_d    = xt_q;
    lfa_d   = lfa_q;
    here_d  = here_q;
    hofs    = 16'(OFS_LFA);
    use_tib = 1'b0;
    mem_vi  = '0;
    mem_we  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RD;
          i_d     = '0;
          ai_d    = ai;
          xt_d    = xt;
        end
      end
      ST_RD: begin
        use_tib = 1'b1;
        state_d = ST_WR;
      end
      ST_WR: begin
        hofs = 16'(OFS_NAME) + 16'(i_q);
        if (mem_vo != '0) begin
          if (i_q == IW'(MAXLEN)) begin
            state_d = ST_ERR;
          end else begin
            mem_we  = 1'b1;
            mem_vi  = mem_vo;
            i_d     = i_q + 1'b1;
            state_d = ST_RD;
          end
        end else if (i_q == '0) begin
          state_d = ST_ERR;
        end else begin
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        hofs    = 16'(OFS_LEN);
        mem_we  = 1'b1;
        mem_vi  = DSZ'(i_q);
        state_d = ST_LFA0;
      end
      ST_LFA0: begin
        hofs    = 16'(OFS_LFA);
        mem_we  = 1'b1;
        mem_vi  = DSZ'(lfa_q[7:0]);
        state_d = ST_LFA1;
      end
      ST_LFA1: begin
        hofs    = 16'(OFS_LFA + 1);
        mem_we  = 1'b1;
        mem_vi  = DSZ'(lfa_q[15:8]);
        state_d = ST_PF0;
      end
      ST_PF0: begin
        hofs    = 16'(OFS_NAME) + 16'(i_q);
        mem_we  = 1'b1;
        mem_vi  = DSZ'(xt_q[7:0]);
        state_d = ST_PF1;
      end
      ST_PF1: begin
        hofs    = 16'(OFS_NAME + 1) + 16'(i_q);
        mem_we  = 1'b1;
        mem_vi  = DSZ'(xt_q[15:8]);
        // Link here so lfa/here already show the new entry while done is high.
        lfa_d   = here_q;
        here_d  = here_q + 16'(OFS_NAME + PFA_SZ) + 16'(i_q);
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_ai = (state_q == ST_IDLE) ? '0 : (use_tib ? tadr : ASZ'(hadr));
  assign bsy    = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign err    = (state_q == ST_ERR);
  assign lfa    = lfa_q;
  assign here   = here_q;

endmodule

// File: tb/tb_dict_add.sv
// Directed bench for dict_add with a synchronous byte memory model.
module tb_dict_add;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [16:0] ai = '0;
  logic [15:0] xt = '0;
  logic        bsy, done, err;
  logic [15:0] lfa, here;
  logic [16:0] mem_ai;
  logic [7:0]  mem_vi, mem_vo;
  logic        mem_we;

  logic        tb_we = 1'b0;
  logic [16:0] tb_a = '0;
  logic [7:0]  tb_d = '0;
  logic [7:0]  mem [0:(1<<17)-1];

  int passes = 0;
  int total  = 0;

  always #5 clk = ~clk;

  dict_add #(.ASZ(17), .DSZ(8), .DICT(16'h0010), .MAXLEN(31)) dut (
    .clk(clk), .rst(rst), .start(start), .ai(ai), .xt(xt),
    .bsy(bsy), .done(done), .err(err), .lfa(lfa), .here(here),
    .mem_ai(mem_ai), .mem_vi(mem_vi), .mem_we(mem_we), .mem_vo(mem_vo)
  );

  always @(posedge clk) begin
    if (tb_we) mem[tb_a] <= tb_d;
    else if (mem_we) mem[mem_ai] <= mem_vi;
    mem_vo <= mem[mem_ai];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic poke(input logic [16:0] a, input logic [7:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_a = a; tb_d = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic put_str(input logic [16:0] a, input string s);
    for (int k = 0; k < s.len(); k++) poke(a + 17'(k), s[k]);
    poke(a + 17'(s.len()), 8'h00);
  endtask

  task automatic chk_bytes(input string tag, input logic [16:0] a, input logic [7:0] exp[]);
    for (int k = 0; k < exp.size(); k++)
      chk($sformatf("%s[%0d]", tag, k), {24'h0, mem[a + 17'(k)]}, {24'h0, exp[k]});
  endtask

  // Issue one command; midstart_at>0 pulses start with altered ai/xt in that cycle.
  task automatic run(input logic [16:0] a, input logic [15:0] x, input int midstart_at,
                     output int dcyc, output int ecyc, output int wes);
    dcyc = -1; ecyc = -1; wes = 0;
    @(negedge clk);
    ai = a; xt = x; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      if (k == midstart_at) begin
        start = 1'b1; ai = 17'h0; xt = 16'hdead;
      end else begin
        start = 1'b0;
      end
      if (mem_we) wes++;
      if (done) begin dcyc = k; break; end
      if (err)  begin ecyc = k; break; end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  function automatic logic [15:0] find(input string s, input logic [15:0] head);
    logic [15:0] p;
    logic [7:0]  n;
    bit          hit;
    p = head;
    for (int g = 0; g < 64 && p != 16'hffff; g++) begin
      n = mem[17'(p) + 17'd2];
      hit = (int'(n) == s.len());
      for (int k = 0; k < s.len() && hit; k++)
        if (mem[17'(p) + 17'd3 + 17'(k)] != s[k]) hit = 0;
      if (hit) return p + 16'd3 + 16'(n);
      p = {mem[17'(p) + 17'd1], mem[17'(p)]};
    end
    return 16'hffff;
  endfunction

  int d, e, w;
  logic [15:0] old_lfa, old_here;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_bsy",  {31'h0, bsy},    32'h0);
    chk("rst_done", {31'h0, done},   32'h0);
    chk("rst_err",  {31'h0, err},    32'h0);
    chk("rst_lfa",  {16'h0, lfa},    32'hffff);
    chk("rst_here", {16'h0, here},   32'h0010);
    chk("rst_mai",  {15'h0, mem_ai}, 32'h0);
    chk("rst_mwe",  {31'h0, mem_we}, 32'h0);
    rst = 1'b0;

    put_str(17'h0, "abcd");
    run(17'h0, 16'hefbe, 0, d, e, w);
    chk("abcd_done_cyc", d, 16);
    chk("abcd_we_cnt", w, 9);
    chk_bytes("abcd_mem", 17'h10, '{8'hff, 8'hff, 8'h04, 8'h61, 8'h62, 8'h63, 8'h64, 8'hbe, 8'hef});
    chk("abcd_lfa",  {16'h0, lfa},  32'h0010);
    chk("abcd_here", {16'h0, here}, 32'h0019);

    put_str(17'h0, "efgh");
    run(17'h0, 16'h5678, 0, d, e, w);
    chk("efgh_done_cyc", d, 16);
    chk_bytes("efgh_hdr", 17'h19, '{8'h10, 8'h00, 8'h04, 8'h65});
    chk("efgh_lfa",  {16'h0, lfa},  32'h0019);
    chk("efgh_here", {16'h0, here}, 32'h0022);
    chk("find_abcd", {16'h0, find("abcd", lfa)}, 32'h0017);
    chk("find_efgh", {16'h0, find("efgh", lfa)}, 32'h0020);

    poke(17'h0, 8'h00);
    run(17'h0, 16'h1111, 0, d, e, w);
    chk("empty_err_cyc", e, 3);
    chk("empty_no_done", d, -1);
    chk("empty_we_cnt", w, 0);
    chk("empty_lfa",  {16'h0, lfa},  32'h0019);
    chk("empty_here", {16'h0, here}, 32'h0022);

    for (int k = 0; k < 32; k++) poke(17'h1000 + 17'(k), 8'h61);
    poke(17'h1020, 8'h00);
    run(17'h1000, 16'h2222, 0, d, e, w);
    chk("long_err", {31'h0, e > 0}, 32'h1);
    chk("long_no_done", d, -1);
    chk("long_we_cnt", w, 31);
    chk("long_lfa",  {16'h0, lfa},  32'h0019);
    chk("long_here", {16'h0, here}, 32'h0022);

    put_str(17'h2000, "xy");
    run(17'h2000, 16'habcd, 0, d, e, w);
    chk("xy_done_cyc", d, 12);
    chk_bytes("xy_mem", 17'h22, '{8'h19, 8'h00, 8'h02, 8'h78, 8'h79, 8'hcd, 8'hab});
    chk("xy_lfa",  {16'h0, lfa},  32'h0022);
    chk("xy_here", {16'h0, here}, 32'h0029);

    put_str(17'h3000, "pq");
    run(17'h3000, 16'h1234, 3, d, e, w);
    chk("pq_done_cyc", d, 12);
    chk_bytes("pq_mem", 17'h29, '{8'h22, 8'h00, 8'h02, 8'h70, 8'h71, 8'h34, 8'h12});
    chk("pq_here", {16'h0, here}, 32'h0030);
    @(negedge clk);
    chk("pq_idle_after", {31'h0, bsy}, 32'h0);

    @(negedge clk);
    ai = 17'h3000; xt = 16'h9999; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_bsy_before_rst", {31'h0, bsy}, 32'h1);
    rst = 1'b1;
    #1;
    chk("mrst_bsy",  {31'h0, bsy},    32'h0);
    chk("mrst_done", {31'h0, done},   32'h0);
    chk("mrst_err",  {31'h0, err},    32'h0);
    chk("mrst_lfa",  {16'h0, lfa},    32'hffff);
    chk("mrst_here", {16'h0, here},   32'h0010);
    chk("mrst_mwe",  {31'h0, mem_we}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    put_str(17'h4000, "abcd");
    run(17'h4000, 16'hefbe, 0, d, e, w);
    chk("post_rst_done_cyc", d, 16);
    chk_bytes("post_rst_mem", 17'h10, '{8'hff, 8'hff, 8'h04, 8'h61, 8'h62, 8'h63, 8'h64, 8'hbe, 8'hef});
    chk("post_rst_lfa",  {16'h0, lfa},  32'h0010);
    chk("post_rst_here", {16'h0, here}, 32'h0019);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
